// File: rtl/ht16d35a_link_sequencer.sv
// Shares one HT16D35A SPI controller between a host command port and a framebuffer refresh engine.
// Defining LINK_SEQ_AUTO_REFRESH_EN builds in the refresh engine and round-robin arbitration.
module ht16d35a_link_sequencer #(
   parameter int         NUM_SELECTS  = 2,
   parameter int         OUT_BYTES    = 8,
   parameter int         OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
   parameter int         PWRUP_CYCLES = 500000,
   parameter int         FB_BYTES     = 32,
   parameter int         FB_ADDR_SZ   = $clog2(FB_BYTES),
   parameter logic [7:0] WRITE_CMD    = 8'h80
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [OUT_BYTES-1:0][7:0] cmd_data,
   input  logic [OUT_BYTES_SZ-1:0]   cmd_count,
   input  logic [NUM_SELECTS-1:0]    cmd_cs,
   input  logic                      refresh_en,
   input  logic [NUM_SELECTS-1:0]    refresh_cs,
   output logic [FB_ADDR_SZ-1:0]     fb_addr,
   input  logic [7:0]                fb_data,
   output logic                      frame_done,
   output logic                      pwrup_done,
   input  logic                      spi_busy,
   output logic                      spi_activate,
   output logic [NUM_SELECTS-1:0]    spi_in_cs,
   output logic [OUT_BYTES-1:0][7:0] spi_out_data,
   output logic [OUT_BYTES_SZ-1:0]   spi_out_count,
   output logic [OUT_BYTES_SZ-1:0]   spi_in_count
);

   localparam int                      PW_SZ        = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
   localparam logic [PW_SZ-1:0]        L_PWRUP_LOAD = (PWRUP_CYCLES > 0) ? PW_SZ'(PWRUP_CYCLES - 1) : '0;
   localparam logic [OUT_BYTES_SZ-1:0] L_OUT_BYTES  = OUT_BYTES_SZ'(OUT_BYTES);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_IDLE,
`ifdef LINK_SEQ_AUTO_REFRESH_EN
      S_FETCH,
`endif
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [PW_SZ-1:0]          r_pwrup_cnt, w_pwrup_cnt_nxt;
   logic                      r_pwrup_done, w_pwrup_done_nxt;
   logic                      r_last_refresh, w_last_refresh_nxt;
   logic                      r_cmd_ready, w_cmd_ready_nxt;
   logic                      r_spi_activate, w_spi_activate_nxt;
   logic [NUM_SELECTS-1:0]    r_spi_in_cs, w_spi_in_cs_nxt;
   logic [OUT_BYTES-1:0][7:0] r_spi_out_data, w_spi_out_data_nxt;
   logic [OUT_BYTES_SZ-1:0]   r_spi_out_count, w_spi_out_count_nxt;
   logic                      w_host_elig;
   logic                      w_ref_elig;
   logic                      w_grant_host;

`ifdef LINK_SEQ_AUTO_REFRESH_EN
   logic [FB_ADDR_SZ-1:0]     r_ptr, w_ptr_nxt;
   logic [FB_ADDR_SZ-1:0]     r_fb_addr, w_fb_addr_nxt;
   logic [OUT_BYTES_SZ-1:0]   r_n, w_n_nxt;
   logic [OUT_BYTES_SZ-1:0]   r_fetch_cnt, w_fetch_cnt_nxt;
   logic [OUT_BYTES_SZ-1:0]   w_chunk;
   logic                      r_frame_done, w_frame_done_nxt;
   logic                      r_is_refresh, w_is_refresh_nxt;
   logic                      w_grant_ref;
   int                        w_rem;
   int                        w_ptr_sum;

   assign w_ref_elig  = refresh_en && (refresh_cs != '0);
   assign w_grant_ref = w_ref_elig && (!w_host_elig || !r_last_refresh);
   assign w_rem       = FB_BYTES - int'(r_ptr);
   assign w_chunk     = (w_rem > OUT_BYTES - 2) ? OUT_BYTES_SZ'(OUT_BYTES - 2) : OUT_BYTES_SZ'(w_rem);
   assign w_ptr_sum   = int'(r_ptr) + int'(r_n);
`else
   logic                      w_unused;

   assign w_ref_elig = 1'b0;
   assign w_unused   = refresh_en ^ (^refresh_cs) ^ (^fb_data);
`endif

   // Round-robin: on a tie the requester that did not win last time gets the link.
   assign w_host_elig  = cmd_valid;
   assign w_grant_host = w_host_elig && (!w_ref_elig || r_last_refresh);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_PWRUP;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_pwrup_cnt_nxt     = r_pwrup_cnt;
      w_pwrup_done_nxt    = r_pwrup_done;
      w_last_refresh_nxt  = r_last_refresh;
      w_cmd_ready_nxt     = 1'b0;
      w_spi_activate_nxt  = r_spi_activate;
      w_spi_in_cs_nxt     = r_spi_in_cs;
      w_spi_out_data_nxt  = r_spi_out_data;
      w_spi_out_count_nxt = r_spi_out_count;
`ifdef LINK_SEQ_AUTO_REFRESH_EN
      w_ptr_nxt           = r_ptr;
      w_fb_addr_nxt       = r_fb_addr;
      w_n_nxt             = r_n;
      w_fetch_cnt_nxt     = r_fetch_cnt;
      w_frame_done_nxt    = 1'b0;
      w_is_refresh_nxt    = r_is_refresh;
`endif
      case (r_state)
         S_PWRUP: begin
            if (r_pwrup_cnt == '0) begin
               w_pwrup_done_nxt = 1'b1;
               w_state_nxt      = S_IDLE;
            end else begin
               w_pwrup_cnt_nxt = r_pwrup_cnt - PW_SZ'(1);
            end
         end
         S_IDLE: begin
            if (!spi_busy) begin
               if (w_grant_host) begin
                  w_last_refresh_nxt  = 1'b0;
                  w_cmd_ready_nxt     = 1'b1;
                  w_spi_out_data_nxt  = cmd_data;
                  w_spi_in_cs_nxt     = cmd_cs;
                  w_spi_out_count_nxt = (cmd_count > L_OUT_BYTES) ? L_OUT_BYTES : cmd_count;
`ifdef LINK_SEQ_AUTO_REFRESH_EN
                  w_is_refresh_nxt    = 1'b0;
`endif
                  if ((cmd_count != '0) && (cmd_cs != '0)) begin
                     w_state_nxt = S_LAUNCH;
                  end
               end
`ifdef LINK_SEQ_AUTO_REFRESH_EN
               else if (w_grant_ref) begin
                  w_last_refresh_nxt    = 1'b1;
                  w_is_refresh_nxt      = 1'b1;
                  w_spi_out_data_nxt    = '0;
                  w_spi_out_data_nxt[0] = WRITE_CMD;
                  w_spi_out_data_nxt[1] = 8'(r_ptr);
                  w_spi_out_count_nxt   = w_chunk + OUT_BYTES_SZ'(2);
                  w_spi_in_cs_nxt       = refresh_cs;
                  w_n_nxt               = w_chunk;
                  w_fb_addr_nxt         = r_ptr;
                  w_fetch_cnt_nxt       = '0;
                  w_state_nxt           = S_FETCH;
               end
`endif
            end
         end
`ifdef LINK_SEQ_AUTO_REFRESH_EN
         // Address runs one cycle ahead of capture because the RAM read is registered.
         S_FETCH: begin
            if ((r_fetch_cnt + OUT_BYTES_SZ'(1)) < r_n) begin
               w_fb_addr_nxt = r_fb_addr + FB_ADDR_SZ'(1);
            end
            for (int b = 2; b < OUT_BYTES; b++) begin
               if ((r_fetch_cnt != '0) && (OUT_BYTES_SZ'(b - 1) == r_fetch_cnt)) begin
                  w_spi_out_data_nxt[b] = fb_data;
               end
            end
            if (r_fetch_cnt == r_n) begin
               w_state_nxt = S_LAUNCH;
            end else begin
               w_fetch_cnt_nxt = r_fetch_cnt + OUT_BYTES_SZ'(1);
            end
         end
`endif
         S_LAUNCH: begin
            if (spi_busy) begin
               w_spi_activate_nxt = 1'b0;
               w_state_nxt        = S_WAIT;
            end else begin
               w_spi_activate_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (!spi_busy) begin
               w_state_nxt = S_IDLE;
`ifdef LINK_SEQ_AUTO_REFRESH_EN
               if (r_is_refresh) begin
                  if (w_ptr_sum >= FB_BYTES) begin
                     w_ptr_nxt        = '0;
                     w_frame_done_nxt = 1'b1;
                  end else begin
                     w_ptr_nxt = FB_ADDR_SZ'(w_ptr_sum);
                  end
               end
`endif
            end
         end
         default: begin
            w_state_nxt = S_PWRUP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwrup_cnt     <= L_PWRUP_LOAD;
         r_pwrup_done    <= 1'b0;
         r_last_refresh  <= 1'b1;
         r_cmd_ready     <= 1'b0;
         r_spi_activate  <= 1'b0;
         r_spi_in_cs     <= '0;
         r_spi_out_data  <= '0;
         r_spi_out_count <= '0;
      end else begin
         r_pwrup_cnt     <= w_pwrup_cnt_nxt;
         r_pwrup_done    <= w_pwrup_done_nxt;
         r_last_refresh  <= w_last_refresh_nxt;
         r_cmd_ready     <= w_cmd_ready_nxt;
         r_spi_activate  <= w_spi_activate_nxt;
         r_spi_in_cs     <= w_spi_in_cs_nxt;
         r_spi_out_data  <= w_spi_out_data_nxt;
         r_spi_out_count <= w_spi_out_count_nxt;
      end
   end

`ifdef LINK_SEQ_AUTO_REFRESH_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr        <= '0;
         r_fb_addr    <= '0;
         r_n          <= '0;
         r_fetch_cnt  <= '0;
         r_frame_done <= 1'b0;
         r_is_refresh <= 1'b0;
      end else begin
         r_ptr        <= w_ptr_nxt;
         r_fb_addr    <= w_fb_addr_nxt;
         r_n          <= w_n_nxt;
         r_fetch_cnt  <= w_fetch_cnt_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_is_refresh <= w_is_refresh_nxt;
      end
   end

   assign fb_addr    = r_fb_addr;
   assign frame_done = r_frame_done;
`else
   assign fb_addr    = '0;
   assign frame_done = 1'b0;
`endif

   assign cmd_ready     = r_cmd_ready;
   assign pwrup_done    = r_pwrup_done;
   assign spi_activate  = r_spi_activate;
   assign spi_in_cs     = r_spi_in_cs;
   assign spi_out_data  = r_spi_out_data;
   assign spi_out_count = r_spi_out_count;
   assign spi_in_count  = '0;

endmodule

// File: tb/tb_ht16d35a_link_sequencer.sv
// Bench for ht16d35a_link_sequencer: behavioural SPI controller, scoreboard of expected transactions.
`timescale 1ns/1ps
module tb_ht16d35a_link_sequencer;

   localparam int NSEL = 2;
   localparam int OB   = 8;
   localparam int OBSZ = 4;
   localparam int PWR  = 20;
   localparam int FBB  = 10;
   localparam int FBA  = 4;

   typedef struct packed {
      logic [NSEL-1:0] cs;
      logic [OBSZ-1:0] count;
      logic [OB*8-1:0] data;
   } txn_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cmdValid = 1'b0;
   logic               cmdReady;
   logic [OB-1:0][7:0] cmdData = '0;
   logic [OBSZ-1:0]    cmdCount = '0;
   logic [NSEL-1:0]    cmdCs = '0;
   logic               refreshEn = 1'b0;
   logic [NSEL-1:0]    refreshCs = '0;
   logic [FBA-1:0]     fbAddr;
   logic [7:0]         fbData = '0;
   logic               frameDone;
   logic               pwrupDone;
   logic               spiBusy = 1'b0;
   logic               spiActivate;
   logic [NSEL-1:0]    spiInCs;
   logic [OB-1:0][7:0] spiOutData;
   logic [OBSZ-1:0]    spiOutCount;
   logic [OBSZ-1:0]    spiInCount;

   int   total = 0;
   int   bad = 0;
   int   frameCnt = 0;
   bit   modelHold = 1'b0;
   logic tickDiv = 1'b0;
   int   busyCnt = 0;
   txn_t expQ[$];
   txn_t obsQ[$];

   ht16d35a_link_sequencer #(
      .NUM_SELECTS (NSEL),
      .OUT_BYTES   (OB),
      .PWRUP_CYCLES(PWR),
      .FB_BYTES    (FBB),
      .WRITE_CMD   (8'h80)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmdValid),
      .cmd_ready    (cmdReady),
      .cmd_data     (cmdData),
      .cmd_count    (cmdCount),
      .cmd_cs       (cmdCs),
      .refresh_en   (refreshEn),
      .refresh_cs   (refreshCs),
      .fb_addr      (fbAddr),
      .fb_data      (fbData),
      .frame_done   (frameDone),
      .pwrup_done   (pwrupDone),
      .spi_busy     (spiBusy),
      .spi_activate (spiActivate),
      .spi_in_cs    (spiInCs),
      .spi_out_data (spiOutData),
      .spi_out_count(spiOutCount),
      .spi_in_count (spiInCount)
   );

   always #5 clk = ~clk;

   // Synchronous framebuffer RAM holding addr+1 at every address.
   always @(posedge clk) fbData <= {4'h0, fbAddr} + 8'd1;

   // SPI controller model: samples activate on every other clock, then stays busy for a while.
   always @(posedge clk) begin
      if (reset) begin
         spiBusy <= 1'b0;
         busyCnt <= 0;
         tickDiv <= 1'b0;
      end else begin
         tickDiv <= ~tickDiv;
         if (spiBusy) begin
            if (busyCnt == 0) spiBusy <= 1'b0;
            else busyCnt <= busyCnt - 1;
         end else if (tickDiv && spiActivate && !modelHold) begin
            spiBusy <= 1'b1;
            busyCnt <= 5;
            obsQ.push_back({spiInCs, spiOutCount, spiOutData});
         end
      end
   end

   always @(negedge clk) if (frameDone) frameCnt++;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_activate"}, spiActivate, 1'b0);
      checkVal({tag, "_ready"}, cmdReady, 1'b0);
      checkVal({tag, "_pwrup"}, pwrupDone, 1'b0);
      checkVal({tag, "_data"}, spiOutData, '0);
      checkVal({tag, "_ctl"}, {spiOutCount, spiInCs, spiInCount, fbAddr, frameDone}, '0);
   endtask

   task automatic applyStimulus(input logic [3:0] cnt, input logic [1:0] cs, input logic [63:0] data,
                                input string tag);
      bit   seen = 1'b0;
      txn_t e;
      cmdCount = cnt;
      cmdCs    = cs;
      cmdData  = data;
      cmdValid = 1'b1;
      for (int n = 0; n < 100 && !seen; n++) begin
         tick();
         if (cmdReady) seen = 1'b1;
      end
      cmdValid = 1'b0;
      checkVal({tag, "_ready"}, seen, 1'b1);
      e.cs    = cs;
      e.count = (cnt > 4'd8) ? 4'd8 : cnt;
      e.data  = data;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      txn_t o;
      txn_t e;
      for (int n = 0; n < 200 && obsQ.size() == 0; n++) tick();
      checkVal({tag, "_arrived"}, obsQ.size() != 0, 1'b1);
      if (obsQ.size() != 0 && expQ.size() != 0) begin
         o = obsQ.pop_front();
         e = expQ.pop_front();
         checkVal(tag, o, e);
      end
   endtask

   task automatic waitQuiet(input string tag);
      int q = 0;
      for (int n = 0; n < 200 && q < 3; n++) begin
         tick();
         if (!spiBusy && !spiActivate) q++;
         else q = 0;
      end
      checkVal({tag, "_quiet"}, q >= 3, 1'b1);
   endtask

   task automatic sendDegenerate(input logic [3:0] cnt, input logic [1:0] cs, input string tag);
      bit seen = 1'b0;
      bit act = 1'b0;
      cmdCount = cnt;
      cmdCs    = cs;
      cmdData  = 64'hDEAD_BEEF_0BAD_F00D;
      cmdValid = 1'b1;
      for (int n = 0; n < 50 && !seen; n++) begin
         tick();
         if (cmdReady) seen = 1'b1;
         if (spiActivate) act = 1'b1;
      end
      cmdValid = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (spiActivate) act = 1'b1;
      end
      checkVal({tag, "_ready"}, seen, 1'b1);
      checkVal({tag, "_no_activate"}, act, 1'b0);
   endtask

`ifdef LINK_SEQ_AUTO_REFRESH_EN
   function automatic txn_t mkRefresh(input int ptr, input int n);
      txn_t t;
      t            = '0;
      t.cs         = 2'b10;
      t.count      = 4'(n + 2);
      t.data[7:0]  = 8'h80;
      t.data[15:8] = 8'(ptr);
      for (int i = 0; i < n; i++) t.data[8*(i+2) +: 8] = 8'(ptr + i + 1);
      return t;
   endfunction
`endif

   initial begin
      int   firstDone = 0;
      int   firstReady = 0;
      int   firstAct = 0;
      int   readyPulses = 0;
      bit   earlyAct = 1'b0;
      bit   seenAct = 1'b0;
      int   c = 0;
      int   frameBase = 0;
      txn_t e;

      $display("[TB] reset state");
      reset = 1'b1;
      repeat (3) tick();
      checkResetOutputs("rst");

      $display("[TB] power-up hold with host request pending");
      cmdData    = '0;
      cmdData[2] = 8'h35;
      cmdData[1] = 8'h03;
      cmdData[0] = 8'hAA;
      cmdCount   = 4'd3;
      cmdCs      = 2'b01;
      cmdValid   = 1'b1;
      e.cs       = 2'b01;
      e.count    = 4'd3;
      e.data     = cmdData;
      expQ.push_back(e);
      reset = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (pwrupDone && firstDone == 0) firstDone = cyc;
         if (cmdReady) begin
            readyPulses++;
            if (firstReady == 0) firstReady = cyc;
            cmdValid = 1'b0;
         end
         if (spiActivate && firstAct == 0) firstAct = cyc;
         if (spiActivate && cyc < PWR) earlyAct = 1'b1;
      end
      checkVal("pwrup_no_early_activate", earlyAct, 1'b0);
      checkVal("pwrup_done_cycle", firstDone, PWR);
      checkVal("pwrup_ready_cycle", firstReady, PWR + 1);
      checkVal("host_activate_cycle", firstAct, PWR + 2);
      checkVal("host_ready_pulses", readyPulses, 1);
      checkOutput("host_write");
      waitQuiet("host_write");

      $display("[TB] degenerate host requests");
      sendDegenerate(4'd0, 2'b01, "degen_count0");
      sendDegenerate(4'd2, 2'b00, "degen_cs0");

      $display("[TB] host clamp and assorted patterns");
      applyStimulus(4'd12, 2'b11, 64'h0102_0304_0506_0708, "clamp");
      checkOutput("clamp");
      waitQuiet("clamp");
      applyStimulus(4'd8, 2'b10, 64'hFFEE_DDCC_BBAA_9988, "full");
      checkOutput("full");
      waitQuiet("full");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'($urandom_range(1, 8)), 2'($urandom_range(1, 3)), {$urandom, $urandom}, "rand");
         checkOutput("rand");
         waitQuiet("rand");
      end

      $display("[TB] reset during launch");
      modelHold = 1'b1;
      cmdCount  = 4'd4;
      cmdCs     = 2'b10;
      cmdData   = 64'h5555_AAAA_1234_5678;
      cmdValid  = 1'b1;
      for (int n = 0; n < 50 && !seenAct; n++) begin
         tick();
         if (spiActivate) seenAct = 1'b1;
      end
      cmdValid = 1'b0;
      checkVal("mid_launch_reached", seenAct, 1'b1);
      reset = 1'b1;
      tick();
      checkResetOutputs("mid_rst");
      modelHold = 1'b0;
      tick();
      reset = 1'b0;
      seenAct = 1'b0;
      c = 0;
      for (int n = 1; n <= 40 && c == 0; n++) begin
         tick();
         if (spiActivate) seenAct = 1'b1;
         if (pwrupDone) c = n;
      end
      checkVal("mid_pwrup_restart", c, PWR);
      checkVal("mid_no_activate", seenAct, 1'b0);
      checkVal("mid_no_txn", obsQ.size(), 0);

`ifdef LINK_SEQ_AUTO_REFRESH_EN
      $display("[TB] refresh chunking");
      frameBase = frameCnt;
      refreshCs = 2'b10;
      expQ.push_back(mkRefresh(0, 6));
      expQ.push_back(mkRefresh(6, 4));
      refreshEn = 1'b1;
      checkOutput("ref_chunk0");
      checkOutput("ref_chunk1");
      refreshEn = 1'b0;
      waitQuiet("ref");
      checkVal("ref_frame_done", frameCnt - frameBase, 1);

      $display("[TB] round-robin with both requesters held");
      cmdData  = 64'h1122_3344_5566_7788;
      cmdCount = 4'd5;
      cmdCs    = 2'b11;
      e.cs     = 2'b11;
      e.count  = 4'd5;
      e.data   = 64'h1122_3344_5566_7788;
      expQ.push_back(e);
      expQ.push_back(mkRefresh(0, 6));
      expQ.push_back(e);
      expQ.push_back(mkRefresh(6, 4));
      cmdValid  = 1'b1;
      refreshEn = 1'b1;
      checkOutput("rr_host1");
      checkOutput("rr_ref1");
      checkOutput("rr_host2");
      checkOutput("rr_ref2");
      cmdValid  = 1'b0;
      refreshEn = 1'b0;
      waitQuiet("rr");
      checkVal("rr_frame_done", frameCnt - frameBase, 2);
      checkVal("rr_no_extra", obsQ.size(), 0);
`endif

      checkVal("frame_done_count_final", frameCnt - frameBase,
`ifdef LINK_SEQ_AUTO_REFRESH_EN
               2
`else
               0
`endif
      );
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ht16d35a_link_sequencer.md
# ht16d35a_link_sequencer

Sequences and shares a single `spi_controller_ht16d35a` instance between two requesters: a host command port and an automatic framebuffer refresh engine. It waits out the HT16D35A power-up time and then arbitrates transactions round-robin. It builds each refresh transaction from a synchronous framebuffer RAM, and runs the activate/busy handshake with the SPI controller. It sits between the display-control logic and the SPI controller, driving the controller's `activate`, `in_cs`, `out_data`, `out_count` and `in_count` inputs.

## Interface
- `NUM_SELECTS`, 2: chip-select width; must match the SPI controller.
- `OUT_BYTES`, 8: transaction buffer depth in bytes; must match the SPI controller; minimum 3.
- `OUT_BYTES_SZ`, `$clog2(OUT_BYTES+1)`: width of the byte-count fields.
- `PWRUP_CYCLES`, 500000: clocks to wait after reset before the first transaction (10 ms at 50 MHz).
- `FB_BYTES`, 32: framebuffer size in bytes.
- `FB_ADDR_SZ`, `$clog2(FB_BYTES)`: width of `fb_addr`.
- `WRITE_CMD`, 8'h80: first byte of every refresh transaction.
- `clk` in, 1: the block's only clock.
- `reset` in, 1: synchronous, active-high.
- `cmd_valid` in, 1: host request pending.
- `cmd_ready` out, 1: one-cycle pulse when the host request is captured.
- `cmd_data` in, 8×`[OUT_BYTES]`: host bytes to transmit.
- `cmd_count` in, `OUT_BYTES_SZ`: number of host bytes.
- `cmd_cs` in, `NUM_SELECTS`: active-high chip mask for the host request.
- `refresh_en` in, 1: enables the automatic refresh engine.
- `refresh_cs` in, `NUM_SELECTS`: chip mask used for refresh transactions.
- `fb_addr` out, `FB_ADDR_SZ`: framebuffer read address.
- `fb_data` in, 8: framebuffer read data, valid 1 cycle after `fb_addr`.
- `frame_done` out, 1: one-cycle pulse after the last chunk of a frame completes.
- `pwrup_done` out, 1: high once the power-up wait has finished.
- `spi_busy` in, 1: the SPI controller's `busy` output.
- `spi_activate` out, 1: drives the SPI controller's `activate`.
- `spi_in_cs` out, `NUM_SELECTS`: drives the SPI controller's `in_cs`.
- `spi_out_data` out, 8×`[OUT_BYTES]`: drives the SPI controller's `out_data`.
- `spi_out_count` out, `OUT_BYTES_SZ`: drives the SPI controller's `out_count`.
- `spi_in_count` out: drives the SPI controller's `in_count`; constant 0.

## Operation
- **All outputs are registered.**
- **Reset values:** every output is 0, including `spi_out_data` and `fb_addr`. The state machine enters `S_PWRUP`, the chunk pointer `ptr` is 0, and `last_grant` is REFRESH.
- **Reset mid-operation** abandons the current transaction and restarts the power-up wait. The SPI controller shares the same reset.
- **`S_PWRUP`:** counts down `PWRUP_CYCLES`, then sets `pwrup_done` and moves to `S_IDLE`. Requests arriving during this state stay pending.
- **`S_IDLE`:** waits until `spi_busy==0`, then arbitrates round-robin.
  - Host is eligible when `cmd_valid` is high.
  - Refresh is eligible when `refresh_en` is high and `refresh_cs!=0`.
  - If both are eligible, the one not in `last_grant` wins.
  - If only one is eligible, it wins.
  - The winner is recorded in `last_grant`.
- **Host grant:**
  - Capture `cmd_data`, `cmd_count` and `cmd_cs` into the `spi_*` registers.
  - Pulse `cmd_ready` in the same cycle.
  - If `cmd_count==0` or `cmd_cs==0`, drop the request (`cmd_ready` still pulses) and stay in `S_IDLE`.
  - If `cmd_count>OUT_BYTES`, clamp it to `OUT_BYTES`.
  - Otherwise go to `S_LAUNCH`.
- **Refresh grant:**
  - Compute `n = min(OUT_BYTES-2, FB_BYTES-ptr)`.
  - Set byte0=`WRITE_CMD`, byte1=`ptr`, `spi_out_count = n+2`, `spi_in_cs = refresh_cs`.
  - Go to `S_FETCH`.
- **`S_FETCH`:** drives `fb_addr = ptr+i` for i=0..n-1 and stores `fb_data` into byte i+2 one cycle later. Unused bytes are held at 0. Moves to `S_LAUNCH` after the final capture.
- **`S_LAUNCH`:** holds `spi_activate=1` with all `spi_*` data stable until `spi_busy` is sampled high, then clears `spi_activate` and moves to `S_WAIT`.
- **`S_WAIT`:** waits for `spi_busy==0`.
  - On a refresh transaction, `ptr += n`.
  - If `ptr` reaches `FB_BYTES`, it wraps to 0 and `frame_done` pulses in that cycle.
  - Returns to `S_IDLE`.
- **Refresh disable:** dropping `refresh_en` mid-transaction does not abort the transaction; `ptr` keeps its value, so the next refresh resumes mid-frame.

## Timing
- **Host-request latency (power-up done, SPI idle):**
  - `cmd_ready` pulses 1 cycle after `cmd_valid` is sampled in `S_IDLE`.
  - `spi_activate` rises on the next cycle.
- **Refresh latency:** `spi_activate` rises n+2 cycles after the grant (n fetch cycles plus 1 for fetch latency plus 1 to enter `S_LAUNCH`).
- **Activate hold:** `spi_activate` stays high for up to one SPI half-bit period (the controller samples `activate` only on its half-bit tick) and falls 1 cycle after `spi_busy` is seen high.
- **No back-to-back launches:** a new grant is never made while `spi_busy==1`, so transactions cannot overlap.
- **`frame_done`:** exactly one cycle wide, once per frame.

## Configuration
- **`LINK_SEQ_AUTO_REFRESH_EN` defined:** the refresh engine, framebuffer port and round-robin arbitration are present, as described above.
- **Not defined:**
  - Refresh is never eligible and only the host path exists.
  - `fb_addr` and `frame_done` are tied to 0.
  - `refresh_en`, `refresh_cs` and `fb_data` are ignored.
  - `S_FETCH` is removed.

## Test plan
- **Power-up hold:** with `PWRUP_CYCLES=20`, hold `cmd_valid` from reset. Required: no `spi_activate` before cycle 20; `pwrup_done` rises at cycle 20; `cmd_ready` pulses at cycle 21.
- **Host write:** send `cmd_count=3`, `cmd_data={8'h35,8'h03,8'hAA}`, `cmd_cs=2'b01`. Required: the SPI model sees those 3 bytes on chip 0 only; exactly one `cmd_ready` pulse.
- **Refresh chunking:** with `FB_BYTES=10` and `OUT_BYTES=8`, fill RAM with `addr+1`. Required: transactions `{80,00,01..06}` then `{80,06,07..0A}`; `frame_done` after the second; `ptr` back at 0.
- **Round-robin:** hold both requesters continuously. Required: grants alternate host, refresh, host, … and neither requester is starved.
- **Degenerate host request:** send `cmd_count=0` or `cmd_cs=0`. Required: `cmd_ready` pulses; `spi_activate` never asserts.
- **Reset mid-transaction:** assert `reset` during `S_LAUNCH`. Required: all outputs 0 the next cycle; the power-up wait restarts; `ptr` is 0.
